// File: rtl/uart_word_codec_if.sv
// uart_word_codec_if: RX word, TX frame and UART byte-core signals of the codec. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

interface uart_word_codec_if #(
  parameter int DATA_BITS = 8,
  parameter int RX_BYTES  = 4,
  parameter int TX_BYTES  = 7
);
  logic                          i_rx_done;
  logic [DATA_BITS-1:0]          i_rx_data;
  logic                          i_flush;
  logic [RX_BYTES*DATA_BITS-1:0] o_word;
  logic                          o_word_valid;
  logic                          o_rx_timeout;
  logic [TX_BYTES*DATA_BITS-1:0] i_frame;
  logic                          i_frame_valid;
  logic                          o_frame_ready;
  logic                          o_tx_start;
  logic [DATA_BITS-1:0]          o_tx_data;
  logic                          i_tx_done;
  logic                          o_tx_busy;

  modport slave (
    input  i_rx_done, i_rx_data, i_flush, i_frame, i_frame_valid, i_tx_done,
    output o_word, o_word_valid, o_rx_timeout, o_frame_ready, o_tx_start,
           o_tx_data, o_tx_busy
  );

  modport master (
    output i_rx_done, i_rx_data, i_flush, i_frame, i_frame_valid, i_tx_done,
    input  o_word, o_word_valid, o_rx_timeout, o_frame_ready, o_tx_start,
           o_tx_data, o_tx_busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_word_codec.sv
// uart_word_codec: packs RX bytes into little-endian words (timeout/flush) and
// serialises buffered TX frames to the UART transmitter. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module uart_word_codec #(
  parameter int DATA_BITS  = 8,
  parameter int RX_BYTES   = 4,
  parameter int TX_BYTES   = 7,
  parameter int RX_TIMEOUT = 65535
) (
  input  logic               i_clk,
  input  logic               i_reset,
  uart_word_codec_if.slave   bus
);

  localparam int WORD_W   = RX_BYTES * DATA_BITS;
  localparam int FRAME_W  = TX_BYTES * DATA_BITS;
  localparam int RX_CNT_W = (RX_BYTES > 1) ? $clog2(RX_BYTES) : 1;
  localparam int TX_CNT_W = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
  localparam int TMO_W    = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

  localparam logic [RX_CNT_W-1:0] RX_LAST  = RX_CNT_W'(RX_BYTES - 1);
  localparam logic [TX_CNT_W-1:0] TX_LAST  = TX_CNT_W'(TX_BYTES - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(RX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } tx_state_t;

  // ---------------- RX word assembly ----------------
  logic [WORD_W-1:0]   slots_q, slots_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [RX_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                word_valid_q, word_valid_d;
  logic                rx_tmo_q, rx_tmo_d;

  always_comb begin
    slots_d      = slots_q;
    word_d       = word_q;
    rx_cnt_d     = rx_cnt_q;
    tmo_d        = tmo_q;
    word_valid_d = 1'b0;
    rx_tmo_d     = 1'b0;
    if (bus.i_flush) begin
      rx_cnt_d = '0;
      tmo_d    = '0;
    end else if (bus.i_rx_done) begin
      slots_d[rx_cnt_q*DATA_BITS +: DATA_BITS] = bus.i_rx_data;
      tmo_d = '0;
      if (rx_cnt_q == RX_LAST) begin
        word_d       = slots_d;
        word_valid_d = 1'b1;
        rx_cnt_d     = '0;
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
    end else if (rx_cnt_q != '0) begin
      // Pulse lands RX_TIMEOUT cycles after the count started at zero.
      if (tmo_q == TMO_LAST) begin
        rx_cnt_d = '0;
        tmo_d    = '0;
        rx_tmo_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      slots_q      <= '0;
      word_q       <= '0;
      rx_cnt_q     <= '0;
      tmo_q        <= '0;
      word_valid_q <= 1'b0;
      rx_tmo_q     <= 1'b0;
    end else begin
      slots_q      <= slots_d;
      word_q       <= word_d;
      rx_cnt_q     <= rx_cnt_d;
      tmo_q        <= tmo_d;
      word_valid_q <= word_valid_d;
      rx_tmo_q     <= rx_tmo_d;
    end
  end

  // ---------------- TX frame serialiser ----------------
  tx_state_t           state_q, state_d;
  logic [FRAME_W-1:0]  hold_q, hold_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic [TX_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic                hold_valid_q, hold_valid_d;
  logic                accept;

  assign accept = bus.i_frame_valid & ~hold_valid_q;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    tx_cnt_d     = tx_cnt_q;
    // Accept needs an empty hold, so it never collides with the IDLE reload.
    if (accept) begin
      hold_d       = bus.i_frame;
      hold_valid_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (hold_valid_q) begin
          shift_d      = hold_q;
          hold_valid_d = 1'b0;
          tx_cnt_d     = '0;
          state_d      = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.i_tx_done) begin
          if (tx_cnt_q == TX_LAST) begin
            state_d = S_IDLE;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
            state_d  = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      tx_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      tx_cnt_q     <= tx_cnt_d;
    end
  end

  assign bus.o_word        = word_q;
  assign bus.o_word_valid  = word_valid_q;
  assign bus.o_rx_timeout  = rx_tmo_q;
  assign bus.o_frame_ready = ~hold_valid_q;
  assign bus.o_tx_start    = (state_q == S_START);
  assign bus.o_tx_data     = shift_q[tx_cnt_q*DATA_BITS +: DATA_BITS];
  assign bus.o_tx_busy     = hold_valid_q | (state_q != S_IDLE);

endmodule

`default_nettype wire
